lfsr_word_unpacker: RTL and testbench

//   Downstream consumer of the 247-bit LFSR (lfsr247). Snapshots the LFSR state, slices the low 224 bits

---
 rtl/lfsr_word_unpacker.sv | 108 ++++++++++
 tb/tb_lfsr_word_unpacker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_unpacker.sv
// Takes a snapshot of the LFSR state, cuts its low NWORDS*WORD_W bits into words and streams
// them over valid/ready. It asks the LFSR to advance once per snapshot, so no word is reused.
module lfsr_word_unpacker #(
    parameter int LFSR_W = 247,
    parameter int WORD_W = 32,
    parameter int NWORDS = 7,
    parameter int SETTLE = 2   // must be >= 1
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              run,
    input  logic [LFSR_W-1:0] lfsr_value,
    output logic              lfsr_next,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       words_out
);

    localparam int USED_W = NWORDS * WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  settle_cnt;
    logic [IDX_W-1:0]  idx;
    logic [USED_W-1:0] snap_buf;
    logic              settle_done;
    logic              hs;
    logic              last_word;

    // The LFSR bits above the used slice are dropped on purpose.
    generate
        if (LFSR_W > USED_W) begin : g_discard
            logic unused_hi;
            assign unused_hi = ^lfsr_value[LFSR_W-1:USED_W];
        end
    endgenerate

    assign settle_done = (settle_cnt == CNT_W'(SETTLE - 1));
    assign out_valid   = (state == ST_EMIT);
    assign out_word    = snap_buf[WORD_W-1:0];
    assign hs          = out_valid & out_ready;
    assign last_word   = (idx == IDX_W'(NWORDS - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values and evaluation order between always_ff blocks cannot matter.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_SETTLE: if (settle_done) state_nx = ST_IDLE;
            ST_IDLE:   if (run) state_nx = ST_LOAD;
            ST_LOAD:   state_nx = ST_EMIT;
            ST_EMIT:   if (hs && last_word && !run) state_nx = ST_IDLE;
            default:   state_nx = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            settle_cnt <= '0;
            idx        <= '0;
            snap_buf   <= '0;
            lfsr_next  <= 1'b0;
            words_out  <= 16'd0;
        end else begin
            lfsr_next <= 1'b0;
            if (state == ST_SETTLE && !settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (state == ST_LOAD) begin
                snap_buf  <= lfsr_value[USED_W-1:0];
                idx       <= '0;
                lfsr_next <= 1'b1;
            end
            if (hs) begin
                words_out <= words_out + 16'd1;
                if (!last_word) begin
                    snap_buf <= snap_buf >> WORD_W;
                    idx      <= idx + 1'b1;
                end else if (run) begin
                    // Zero-bubble reload: the LFSR advance from this snapshot has already completed.
                    snap_buf  <= lfsr_value[USED_W-1:0];
                    idx       <= '0;
                    lfsr_next <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_word_unpacker.sv
// Randomised bench for lfsr_word_unpacker. A table of LFSR states advances on lfsr_next, and
// word n of a run is expected to be slice n%7 of snapshot n/7.
module tb_lfsr_word_unpacker;

    localparam int LFSR_W = 247;
    localparam int WORD_W = 32;
    localparam int NWORDS = 7;
    localparam int SETTLE = 2;

    logic              clk = 1'b0;
    logic              init_n;
    logic              run;
    logic [LFSR_W-1:0] lfsr_value;
    logic              lfsr_next;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       words_out;

    logic [LFSR_W-1:0] states [64];
    int                adv      = 0;
    int                exp_snap = 0;
    logic [15:0]       exp_wcnt = 16'd0;
    int                n_cmp    = 0;
    int                n_err    = 0;

    lfsr_word_unpacker #(
        .LFSR_W(LFSR_W), .WORD_W(WORD_W), .NWORDS(NWORDS), .SETTLE(SETTLE)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .run       (run),
        .lfsr_value(lfsr_value),
        .lfsr_next (lfsr_next),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    // LFSR stand-in: one step through the state table per lfsr_next pulse.
    assign lfsr_value = states[adv % 64];
    always @(posedge clk) if (lfsr_next === 1'b1) adv <= adv + 1;

    function automatic logic [WORD_W-1:0] exp_word(input int snap, input int w);
        logic [LFSR_W-1:0] s;
        s = states[snap % 64];
        return s[w*WORD_W +: WORD_W];
    endfunction

    task automatic do_reset(input string name);
        @(negedge clk);
        init_n = 1'b0; run = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_word !== '0 || lfsr_next !== 1'b0 || words_out !== 16'd0) begin
            n_err++;
            $display("FAIL %s outputs_in_reset: valid=%b word=%h next=%b count=%h, want all 0",
                     name, out_valid, out_word, lfsr_next, words_out);
        end
        exp_wcnt = 16'd0;
        @(negedge clk);
        @(negedge clk);
        init_n = 1'b1;
        for (int c = 0; c < SETTLE + 2; c++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || lfsr_next !== 1'b0) begin
                n_err++;
                $display("FAIL %s quiet_after_reset c%0d: valid=%b next=%b, want 0/0",
                         name, c, out_valid, lfsr_next);
            end
            @(negedge clk);
        end
    endtask

    // Stream nwords words starting from IDLE (or from word 0 when skip_start is set).
    task automatic stream(input string name, input int nwords, input int stall_at,
                          input int stall_len, input int drop_run_at, input bit rnd_ready,
                          input int abort_at, input bit skip_start);
        int          base;
        int          stall_left;
        int          rnd_stalls;
        bit          first;
        bit          rdy;
        logic        exp_nx;
        logic [WORD_W-1:0] exp_w;
        base = exp_snap;
        if (!skip_start) begin
            run = 1'b1; out_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || lfsr_next !== 1'b0) begin
                n_err++;
                $display("FAIL %s load_cycle: valid=%b next=%b, want 0/0", name, out_valid, lfsr_next);
            end
            @(negedge clk);
        end
        for (int i = 0; i < nwords; i++) begin
            if (i == abort_at) return;
            exp_w = exp_word(base + i / NWORDS, i % NWORDS);
            if (i % NWORDS == 0) exp_snap = base + i / NWORDS + 1;
            stall_left = (i == stall_at) ? stall_len : 0;
            rnd_stalls = 0;
            first = 1'b1;
            do begin
                if (i == drop_run_at) run = 1'b0;
                if (stall_left > 0) begin
                    rdy = 1'b0; stall_left--;
                end else if (rnd_ready && rnd_stalls < 3 && $urandom_range(0, 3) == 0) begin
                    rdy = 1'b0; rnd_stalls++;
                end else begin
                    rdy = 1'b1;
                end
                exp_nx = (i % NWORDS == 0) && first;
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s valid w%0d: got %b want 1", name, i, out_valid);
                end
                n_cmp++;
                if (out_word !== exp_w) begin
                    n_err++;
                    $display("FAIL %s word w%0d: got %h want %h", name, i, out_word, exp_w);
                end
                n_cmp++;
                if (lfsr_next !== exp_nx) begin
                    n_err++;
                    $display("FAIL %s lfsr_next w%0d: got %b want %b", name, i, lfsr_next, exp_nx);
                end
                n_cmp++;
                if (words_out !== exp_wcnt) begin
                    n_err++;
                    $display("FAIL %s words_out w%0d: got %0d want %0d", name, i, words_out, exp_wcnt);
                end
                first = 1'b0;
                out_ready = rdy;
                @(negedge clk);
                if (rdy) exp_wcnt++;
            end while (!rdy);
        end
        run = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || lfsr_next !== 1'b0 || words_out !== exp_wcnt) begin
                n_err++;
                $display("FAIL %s idle_after c%0d: valid=%b next=%b count=%0d, want 0/0/%0d",
                         name, c, out_valid, lfsr_next, words_out, exp_wcnt);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (adv !== exp_snap) begin
            n_err++;
            $display("FAIL %s pulse_total: lfsr advanced %0d times, want %0d", name, adv, exp_snap);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic();
        for (int w = 0; w < NWORDS; w++) states[exp_snap % 64][w*WORD_W +: WORD_W] = 32'(w + 1);
        stream("basic", 7, -1, 0, 0, 1'b0, -1, 1'b0);
        n_cmp++;
        if (words_out !== 16'd7) begin
            n_err++;
            $display("FAIL basic words_out_total: got %0d want 7", words_out);
        end
    endtask

    task automatic test_backpressure();
        stream("backpressure", 7, 2, 5, 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        stream("back_to_back", 14, -1, 0, 7, 1'b0, -1, 1'b0);
    endtask

    task automatic test_run_drop();
        stream("run_drop", 14, -1, 0, 9, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random_ready();
        stream("random_ready", 35, -1, 0, 31, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        stream("pre_reset", 7, -1, 0, -1, 1'b0, 4, 1'b0);
        init_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_word !== '0 || lfsr_next !== 1'b0 || words_out !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid immediate: valid=%b word=%h next=%b count=%h, want all 0",
                     out_valid, out_word, lfsr_next, words_out);
        end
        exp_wcnt = 16'd0;
        @(negedge clk);
        init_n = 1'b1;
        for (int c = 0; c < SETTLE + 2; c++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || lfsr_next !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid settle c%0d: valid=%b next=%b, want 0/0", c, out_valid, lfsr_next);
            end
            @(negedge clk);
        end
        stream("post_reset", 7, -1, 0, 0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset("wrap_reset");
        stream("wrap", 65541, -1, 0, 65534, 1'b0, -1, 1'b0);
        n_cmp++;
        if (words_out !== 16'd5) begin
            n_err++;
            $display("FAIL wrap final_count: got %0d want 5", words_out);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] tmp;
        for (int i = 0; i < 64; i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            states[i] = tmp[LFSR_W-1:0];
        end
        init_n = 1'b1; run = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_run_drop();
        test_random_ready();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
